gen_chan_arbiter: RTL and testbench
===================================

Name: gen_chan_arbiter

Overview:
- Parametrised N-channel buffered arbiter: one generate-built FIFO per input channel, merged onto a single registered output stream by a round-robin arbiter.
- Successor to the single-instance, parameter-override pattern inside generate scopes; generalised in channel count, data width and buffer depth, with real handshake behaviour.
- Used in regression as a per-channel elaboration, naming and parameter-propagation test with checkable cycle behaviour.

Parameters:
- NUM_CH, 4, number of input channels (>=1)
- WIDTH, 8, data bits per channel
- DEPTH, 2, entries per channel FIFO (power of 2, >=2)
- CHW, derived: max(1, $clog2(NUM_CH)), width of channel index

Ports:
- clk  input  1  sole clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  NUM_CH  per-channel valid
- in_ready  output  NUM_CH  per-channel ready
- in_data  input  NUM_CH*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH]
- out_valid  output  1  output word valid
- out_ready  input  1  downstream accepts
- out_data  output  WIDTH  output word
- out_chan  output  CHW  source channel of out_data

Behaviour:
- Reset (async assert, sync release): all FIFO pointers and counts 0; out_valid=0; out_data=0; out_chan=0; rr_last=NUM_CH-1, so channel 0 has first priority. Reset mid-operation discards all buffered and held words immediately.
- Per-channel FIFO, generated with a loop per channel:
  - in_ready[c] = (count[c] != DEPTH), derived from state only, with no combinational path from out_ready.
  - Push when in_valid[c] && in_ready[c].
  - No push while full, even if the same FIFO pops that cycle.
  - Pop only on an arbiter grant.
  - Simultaneous push and pop on a non-full FIFO leaves the count unchanged.
  - Pointers wrap modulo DEPTH.
- Output stage is a single register (out_valid/out_data/out_chan).
  - load_en = !out_valid || out_ready.
  - When load_en: scan channels rr_last+1, rr_last+2, ... modulo NUM_CH. Grant the first non-empty FIFO: pop it, load out_data=head, out_chan=c, out_valid=1, rr_last=c.
  - When load_en and all FIFOs are empty: out_valid<=0; out_data and out_chan hold.
  - When out_valid && !out_ready: out_data and out_chan are held stable. No pop occurs and rr_last is unchanged.
- Latency: a word pushed at edge k is presented with out_valid=1 after edge k+1 at the earliest. There is no empty-FIFO bypass.
- Throughput: one word per cycle with out_ready held high, while any FIFO is non-empty.
- Fairness: under continuous load on all channels, grants rotate 0,1,...,NUM_CH-1,0. No channel waits more than NUM_CH-1 grants once it is non-empty.
- Ordering: words from one channel leave in push order. No inter-channel ordering is guaranteed.
- NUM_CH=1: arbiter degenerates to a pass-through from the FIFO; out_chan is always 0.
- No X propagation: FIFO storage does not require reset, but out_data must never take X after reset.

Test Plan:
- Reset/idle: rst_n=0 for 3 cycles, then release with in_valid=0 -> out_valid=0, out_data=0x00, out_chan=0, in_ready=4'b1111 for 10 cycles.
- Single word: push 0xA5 on ch2 at edge k, out_ready=1 -> out_valid=1, out_data=0xA5, out_chan=2 after edge k+1; out_valid=0 after edge k+2.
- Round-robin: preload 2 words per channel (ch c: 0x10+c then 0x20+c), then out_ready=1 -> output sequence 0x10,0x11,0x12,0x13,0x20,0x21,0x22,0x23, with out_chan 0,1,2,3,0,1,2,3.
- Backpressure/full: out_ready=0, push 3 words on ch1 -> in_ready[1]=0 after the 2nd push (the 3rd is not accepted). First output 0x.. held stable for 5 cycles. Raise out_ready -> exactly 2 words drain in order.
- Simultaneous push/pop: ch0 holds 1 word; push and grant ch0 in the same cycle for 8 cycles -> count[0] stays 1, data emerges in order, no loss or duplication.
- Async reset mid-stream: assert rst_n=0 between edges while out_valid=1 and FIFOs are non-empty -> out_valid=0 immediately, before the next clk edge. After release, no stale word appears and the first grant goes to ch0.

Source files
------------

// File: rtl/gen_chan_arbiter.sv
// N-channel buffered arbiter: one small FIFO per input channel, merged onto a
// single registered output stream by a round-robin arbiter.
module gen_chan_arbiter #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 2,
  parameter int CHW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [CHW-1:0]          out_chan
);

  localparam int              PW       = $clog2(DEPTH);
  localparam logic [PW:0]     FULL_CNT = (PW + 1)'(DEPTH);
  localparam logic [CHW-1:0]  LAST_CH  = CHW'(NUM_CH - 1);

  logic [NUM_CH-1:0] not_empty;
  logic [NUM_CH-1:0] grant_vec;
  logic [WIDTH-1:0]  head [NUM_CH];
  logic              load_en;
  logic              grant_found;
  logic [CHW-1:0]    grant_idx;
  logic [WIDTH-1:0]  grant_data;
  logic [CHW-1:0]    rr_last;
  logic [CHW-1:0]    cand;
  int                pos;

  // Output register is free to take a new word when empty or being drained.
  assign load_en = !out_valid || out_ready;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             push;
    logic             pop;

    assign in_ready[c]  = (count != FULL_CNT);
    assign push         = in_valid[c] && in_ready[c];
    assign pop          = grant_vec[c];
    assign not_empty[c] = (count != '0);
    assign head[c]      = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end

    // Storage is never read before it has been written, so it needs no reset.
    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_data[c*WIDTH +: WIDTH];
    end
  end

  // Scan starting just after the last granted channel, wrapping around.
  always_comb begin
    grant_vec   = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_data  = '0;
    cand        = '0;
    pos         = 0;
    if (load_en) begin
      for (int i = 1; i <= NUM_CH; i++) begin
        pos = int'(rr_last) + i;
        if (pos >= NUM_CH) pos = pos - NUM_CH;
        cand = CHW'(pos);
        if (!grant_found && not_empty[cand]) begin
          grant_found     = 1'b1;
          grant_idx       = cand;
          grant_vec[cand] = 1'b1;
          grant_data      = head[cand];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      rr_last   <= LAST_CH;
    end else if (load_en) begin
      if (grant_found) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_chan  <= grant_idx;
        rr_last   <= grant_idx;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gen_chan_arbiter.sv
// Self-checking bench for gen_chan_arbiter: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_gen_chan_arbiter;

  localparam int NUM_CH = 4;
  localparam int WIDTH  = 8;
  localparam int DEPTH  = 2;
  localparam int CHW    = 2;

  logic                    clk;
  logic                    rst_n;
  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH-1:0]       in_ready;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        out_data;
  logic [CHW-1:0]          out_chan;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] mq [NUM_CH][$];
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic [CHW-1:0]   m_chan;
  int               m_last;

  gen_chan_arbiter #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_chan  (out_chan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) mq[c].delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_chan  = '0;
    m_last  = NUM_CH - 1;
  endtask

  // Drive one cycle of inputs, let one rising edge pass, then advance the model.
  task automatic step(input logic [NUM_CH-1:0] v, input logic [NUM_CH*WIDTH-1:0] d,
                      input logic r);
    logic [NUM_CH-1:0] acc;
    int found;
    int idx;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    for (int c = 0; c < NUM_CH; c++) acc[c] = v[c] && (mq[c].size() < DEPTH);
    @(posedge clk);
    #1;
    if (!m_valid || r) begin
      found = -1;
      for (int i = 1; i <= NUM_CH; i++) begin
        idx = (m_last + i) % NUM_CH;
        if (found < 0 && mq[idx].size() > 0) found = idx;
      end
      if (found >= 0) begin
        m_data  = mq[found].pop_front();
        m_chan  = CHW'(found);
        m_last  = found;
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
    end
    for (int c = 0; c < NUM_CH; c++)
      if (acc[c]) mq[c].push_back(d[c*WIDTH +: WIDTH]);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_chan !== 2'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_held: got v=%b d=%h c=%0d want v=0 d=00 c=0",
               out_valid, out_data, out_chan);
    end
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      step('0, '0, 1'($urandom_range(1)));
      n_checks++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || out_chan !== 2'd0 ||
          in_ready !== 4'b1111) begin
        n_fail++;
        $display("[TB] FAIL reset_idle cyc %0d: got v=%b d=%h c=%0d rdy=%b want v=0 d=00 c=0 rdy=1111",
                 i, out_valid, out_data, out_chan, in_ready);
      end
    end
  endtask

  task automatic test_single_word();
    do_reset();
    step(4'b0100, 32'h00A50000, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL single_no_bypass: got v=%b want v=0", out_valid);
    end
    step('0, '0, 1'b1);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_chan !== 2'd2) begin
      n_fail++;
      $display("[TB] FAIL single_out: got v=%b d=%h c=%0d want v=1 d=a5 c=2",
               out_valid, out_data, out_chan);
    end
    step('0, '0, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 8'hA5 || out_chan !== 2'd2) begin
      n_fail++;
      $display("[TB] FAIL single_after: got v=%b d=%h c=%0d want v=0 d=a5 c=2 (held)",
               out_valid, out_data, out_chan);
    end
  endtask

  task automatic test_round_robin();
    logic [WIDTH-1:0] exp_d;
    logic [CHW-1:0]   exp_c;
    do_reset();
    step(4'b1111, 32'h13121110, 1'b0);
    step(4'b1111, 32'h23222120, 1'b0);
    for (int j = 0; j < 8; j++) begin
      if (j > 0) step('0, '0, 1'b1);
      exp_d = (j < 4) ? WIDTH'(8'h10 + j) : WIDTH'(8'h20 + j - 4);
      exp_c = CHW'(j % NUM_CH);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== exp_d || out_chan !== exp_c) begin
        n_fail++;
        $display("[TB] FAIL rr_word %0d: got v=%b d=%h c=%0d want v=1 d=%h c=%0d",
                 j, out_valid, out_data, out_chan, exp_d, exp_c);
      end
    end
    step('0, '0, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL rr_drained: got v=%b want v=0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    step(4'b0001, 32'h0000000F, 1'b0);
    step('0, '0, 1'b0);
    step(4'b0010, 32'h00003100, 1'b0);
    n_checks++;
    if (in_ready[1] !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL bp_ready_1st: got %b want 1", in_ready[1]);
    end
    step(4'b0010, 32'h00003200, 1'b0);
    n_checks++;
    if (in_ready[1] !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL bp_full_2nd: got %b want 0", in_ready[1]);
    end
    step(4'b0010, 32'h00003300, 1'b0);
    n_checks++;
    if (in_ready[1] !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL bp_full_3rd: got %b want 0", in_ready[1]);
    end
    for (int i = 0; i < 5; i++) begin
      step('0, '0, 1'b0);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h0F || out_chan !== 2'd0) begin
        n_fail++;
        $display("[TB] FAIL bp_hold cyc %0d: got v=%b d=%h c=%0d want v=1 d=0f c=0",
                 i, out_valid, out_data, out_chan);
      end
    end
    step('0, '0, 1'b1);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h31 || out_chan !== 2'd1) begin
      n_fail++;
      $display("[TB] FAIL bp_drain0: got v=%b d=%h c=%0d want v=1 d=31 c=1",
               out_valid, out_data, out_chan);
    end
    step('0, '0, 1'b1);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h32 || out_chan !== 2'd1) begin
      n_fail++;
      $display("[TB] FAIL bp_drain1: got v=%b d=%h c=%0d want v=1 d=32 c=1",
               out_valid, out_data, out_chan);
    end
    step('0, '0, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL bp_drain_end: got v=%b want v=0", out_valid);
    end
  endtask

  task automatic test_simul_push_pop();
    logic [WIDTH-1:0] exp_d;
    do_reset();
    step(4'b0001, 32'h00000040, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(4'b0001, {24'h0, WIDTH'(8'h41 + i)}, 1'b1);
      exp_d = WIDTH'(8'h40 + i);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== exp_d || out_chan !== 2'd0 ||
          in_ready[0] !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL pushpop cyc %0d: got v=%b d=%h c=%0d rdy0=%b want v=1 d=%h c=0 rdy0=1",
                 i, out_valid, out_data, out_chan, in_ready[0], exp_d);
      end
    end
    step('0, '0, 1'b1);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h48) begin
      n_fail++;
      $display("[TB] FAIL pushpop_last: got v=%b d=%h want v=1 d=48", out_valid, out_data);
    end
    step('0, '0, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL pushpop_empty: got v=%b want v=0", out_valid);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(4'b1111, 32'h53525150, 1'b0);
    step(4'b1111, 32'h63626160, 1'b0);
    step(4'b1111, 32'h73727170, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h50) begin
      n_fail++;
      $display("[TB] FAIL areset_pre: got v=%b d=%h want v=1 d=50", out_valid, out_data);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_chan !== 2'd0 ||
        in_ready !== 4'b1111) begin
      n_fail++;
      $display("[TB] FAIL areset_now: got v=%b d=%h c=%0d rdy=%b want v=0 d=00 c=0 rdy=1111",
               out_valid, out_data, out_chan, in_ready);
    end
    in_valid = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      step('0, '0, 1'b1);
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL areset_stale cyc %0d: got v=%b want v=0", i, out_valid);
      end
    end
    step(4'b1001, 32'h93000090, 1'b1);
    step('0, '0, 1'b1);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h90 || out_chan !== 2'd0) begin
      n_fail++;
      $display("[TB] FAIL areset_first: got v=%b d=%h c=%0d want v=1 d=90 c=0",
               out_valid, out_data, out_chan);
    end
    step('0, '0, 1'b1);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h93 || out_chan !== 2'd3) begin
      n_fail++;
      $display("[TB] FAIL areset_second: got v=%b d=%h c=%0d want v=1 d=93 c=3",
               out_valid, out_data, out_chan);
    end
  endtask

  task automatic test_random();
    logic [NUM_CH*WIDTH-1:0] d;
    logic [NUM_CH-1:0]       exp_rdy;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < NUM_CH; c++) d[c*WIDTH +: WIDTH] = WIDTH'($urandom);
      step(NUM_CH'($urandom), d, ($urandom_range(3) != 0));
      for (int c = 0; c < NUM_CH; c++) exp_rdy[c] = (mq[c].size() != DEPTH);
      n_checks++;
      if (out_valid !== m_valid || out_data !== m_data || out_chan !== m_chan ||
          in_ready !== exp_rdy) begin
        n_fail++;
        $display("[TB] FAIL random cyc %0d: got v=%b d=%h c=%0d rdy=%b want v=%b d=%h c=%0d rdy=%b",
                 i, out_valid, out_data, out_chan, in_ready, m_valid, m_data, m_chan, exp_rdy);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_word();
    test_round_robin();
    test_backpressure();
    test_simul_push_pop();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
